// File: rtl/cache_data_array.sv
// Set-associative L1 cache data array: per-way SRAM banks, two-stage read
// pipeline with write forwarding, full-line fill port and byte-masked store port.
module cache_data_array #(
  parameter  int NUM_WAYS         = 4,
  parameter  int NUM_SETS         = 16,
  parameter  int CACHE_LINE_BYTES = 64,
  parameter  int WORD_BYTES       = 4,
  localparam int WAY_W            = $clog2(NUM_WAYS),
  localparam int SET_W            = $clog2(NUM_SETS),
  localparam int LINE_W           = 8 * CACHE_LINE_BYTES,
  localparam int WORD_W           = 8 * WORD_BYTES,
  localparam int WIDX_W           = $clog2(CACHE_LINE_BYTES / WORD_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        access_en,
  input  logic [SET_W-1:0]            access_set_idx,
  input  logic                        hit_en,
  input  logic [WAY_W-1:0]            hit_way_idx,
  input  logic [WIDX_W-1:0]           hit_word_idx,
  output logic                        data_valid,
  output logic [LINE_W-1:0]           data_line,
  output logic [WORD_W-1:0]           data_word,
  input  logic                        fill_en,
  input  logic [WAY_W-1:0]            fill_way_idx,
  input  logic [SET_W-1:0]            fill_set_idx,
  input  logic [LINE_W-1:0]           fill_data,
  input  logic                        store_en,
  output logic                        store_ready,
  input  logic [WAY_W-1:0]            store_way_idx,
  input  logic [SET_W-1:0]            store_set_idx,
  input  logic [CACHE_LINE_BYTES-1:0] store_byte_en,
  input  logic [LINE_W-1:0]           store_data
);

  function automatic logic [LINE_W-1:0] merge_bytes(
    input logic [LINE_W-1:0]           base,
    input logic [LINE_W-1:0]           upd,
    input logic [CACHE_LINE_BYTES-1:0] mask
  );
    logic [LINE_W-1:0] res;
    for (int b = 0; b < CACHE_LINE_BYTES; b++) begin
      if (mask[b]) res[8*b +: 8] = upd[8*b +: 8];
      else         res[8*b +: 8] = base[8*b +: 8];
    end
    return res;
  endfunction

  logic [LINE_W-1:0]           mem_r     [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0]           s1_line_r [NUM_WAYS];
  logic [SET_W-1:0]            s1_set_r;
  logic                        s1_valid_r;
  logic [LINE_W-1:0]           byp_data_r [NUM_WAYS];
  logic [CACHE_LINE_BYTES-1:0] byp_mask_r [NUM_WAYS];
  logic [LINE_W-1:0]           byp_data_s [NUM_WAYS];
  logic [CACHE_LINE_BYTES-1:0] byp_mask_s [NUM_WAYS];
  logic                        fill_commit_s;
  logic                        store_commit_s;
  logic [LINE_W-1:0]           fwd_a_s;
  logic [LINE_W-1:0]           fwd_b_s;
  logic                        data_valid_r;
  logic [LINE_W-1:0]           data_line_r;
  logic [WORD_W-1:0]           data_word_r;

  // Fill always wins a same-way conflict; writes are ignored while in reset.
  assign store_ready    = rst | ~(fill_en & (fill_way_idx == store_way_idx));
  assign fill_commit_s  = fill_en & ~rst;
  assign store_commit_s = store_en & store_ready & ~rst;

  // SRAM banks: byte-masked writes, contents never reset.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      for (int b = 0; b < CACHE_LINE_BYTES; b++) begin
        if (fill_commit_s && fill_way_idx == WAY_W'(w))
          mem_r[w][fill_set_idx][8*b +: 8] <= fill_data[8*b +: 8];
        if (store_commit_s && store_way_idx == WAY_W'(w) && store_byte_en[b])
          mem_r[w][store_set_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  // Capture writes landing on the set being read this cycle, one entry per way.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      byp_data_s[w] = '0;
      byp_mask_s[w] = '0;
      if (access_en && fill_commit_s && fill_way_idx == WAY_W'(w) &&
          fill_set_idx == access_set_idx) begin
        byp_data_s[w] = fill_data;
        byp_mask_s[w] = {CACHE_LINE_BYTES{1'b1}};
      end else if (access_en && store_commit_s && store_way_idx == WAY_W'(w) &&
                   store_set_idx == access_set_idx) begin
        byp_data_s[w] = store_data;
        byp_mask_s[w] = store_byte_en;
      end else begin
        byp_mask_s[w] = '0;
      end
    end
  end

  // Stage-1 SRAM read data and set (datapath, not reset).
  always_ff @(posedge clk) begin
    if (access_en) begin
      s1_set_r <= access_set_idx;
      for (int w = 0; w < NUM_WAYS; w++) s1_line_r[w] <= mem_r[w][access_set_idx];
    end
  end

  // Stage-1 valid and bypass registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        byp_data_r[w] <= '0;
        byp_mask_r[w] <= '0;
      end
    end else begin
      s1_valid_r <= access_en;
      for (int w = 0; w < NUM_WAYS; w++) begin
        byp_data_r[w] <= byp_data_s[w];
        byp_mask_r[w] <= byp_mask_s[w];
      end
    end
  end

  // Stage-2 way select and forwarding: SRAM, then bypass register, then live write.
  always_comb begin
    fwd_a_s = merge_bytes(s1_line_r[hit_way_idx], byp_data_r[hit_way_idx],
                          byp_mask_r[hit_way_idx]);
    fwd_b_s = fwd_a_s;
    if (fill_commit_s && fill_set_idx == s1_set_r && fill_way_idx == hit_way_idx) begin
      fwd_b_s = fill_data;
    end else if (store_commit_s && store_set_idx == s1_set_r &&
                 store_way_idx == hit_way_idx) begin
      fwd_b_s = merge_bytes(fwd_a_s, store_data, store_byte_en);
    end else begin
      fwd_b_s = fwd_a_s;
    end
  end

  // Stage-2 output registers; line and word hold when no hit is delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid_r <= 1'b0;
      data_line_r  <= '0;
      data_word_r  <= '0;
    end else begin
      data_valid_r <= s1_valid_r & hit_en;
      if (s1_valid_r && hit_en) begin
        data_line_r <= fwd_b_s;
        data_word_r <= fwd_b_s[hit_word_idx*WORD_W +: WORD_W];
      end
    end
  end

  assign data_valid = data_valid_r;
  assign data_line  = data_line_r;
  assign data_word  = data_word_r;

endmodule

// File: tb/tb_cache_data_array.sv
// Directed, table-driven bench for cache_data_array with a line-level memory model.
module tb_cache_data_array;

  logic         clk = 1'b0;
  logic         rst;
  logic         access_en;
  logic [3:0]   access_set_idx;
  logic         hit_en;
  logic [1:0]   hit_way_idx;
  logic [3:0]   hit_word_idx;
  logic         data_valid;
  logic [511:0] data_line;
  logic [31:0]  data_word;
  logic         fill_en;
  logic [1:0]   fill_way_idx;
  logic [3:0]   fill_set_idx;
  logic [511:0] fill_data;
  logic         store_en;
  logic         store_ready;
  logic [1:0]   store_way_idx;
  logic [3:0]   store_set_idx;
  logic [63:0]  store_byte_en;
  logic [511:0] store_data;

  always #5 clk = ~clk;

  cache_data_array dut (
    .clk(clk), .rst(rst),
    .access_en(access_en), .access_set_idx(access_set_idx),
    .hit_en(hit_en), .hit_way_idx(hit_way_idx), .hit_word_idx(hit_word_idx),
    .data_valid(data_valid), .data_line(data_line), .data_word(data_word),
    .fill_en(fill_en), .fill_way_idx(fill_way_idx), .fill_set_idx(fill_set_idx),
    .fill_data(fill_data),
    .store_en(store_en), .store_ready(store_ready), .store_way_idx(store_way_idx),
    .store_set_idx(store_set_idx), .store_byte_en(store_byte_en), .store_data(store_data)
  );

  int checks = 0;
  int errors = 0;
  logic [511:0] model [4][16];

  typedef struct {
    int          set;
    int          way;
    int          word;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    access_en = 1'b0; access_set_idx = '0;
    hit_en = 1'b0; hit_way_idx = '0; hit_word_idx = '0;
    fill_en = 1'b0; fill_way_idx = '0; fill_set_idx = '0; fill_data = '0;
    store_en = 1'b0; store_way_idx = '0; store_set_idx = '0;
    store_byte_en = '0; store_data = '0;
  endtask

  // Line pattern: byte i of (way w, set s) = i + 4*s + 64*w (mod 256).
  function automatic logic [511:0] pat(input int w, input int s);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(i + 4*s + 64*w);
    return r;
  endfunction

  function automatic logic [511:0] apply_mask(input logic [511:0] base, input logic [511:0] d,
                                              input logic [63:0] m);
    logic [511:0] r;
    r = base;
    for (int i = 0; i < 64; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic do_read(input int s, input int w, input int k,
                         output logic v, output logic [511:0] line, output logic [31:0] word);
    access_en = 1'b1; access_set_idx = 4'(s);
    tick();
    access_en = 1'b0; hit_en = 1'b1; hit_way_idx = 2'(w); hit_word_idx = 4'(k);
    tick();
    hit_en = 1'b0;
    v = data_valid; line = data_line; word = data_word;
  endtask

  logic         rv;
  logic [511:0] rl;
  logic [31:0]  rw;
  logic [511:0] y_line;

  initial begin
    idle();
    rst = 1'b1;
    // Conflicting fill/store during reset: store_ready must still be 1.
    fill_en = 1'b1; store_en = 1'b1; store_byte_en = '1;
    tick();
    tick();
    check("reset_store_ready", 512'(store_ready), 512'(1'b1));
    check("reset_valid", 512'(data_valid), 512'(1'b0));
    check("reset_line", data_line, '0);
    check("reset_word", 512'(data_word), '0);
    idle();
    rst = 1'b0;
    tick();

    // Prefill every line, then line L (byte i = i) into way 2 set 5.
    for (int w = 0; w < 4; w++) begin
      for (int s = 0; s < 16; s++) begin
        fill_en = 1'b1; fill_way_idx = 2'(w); fill_set_idx = 4'(s); fill_data = pat(w, s);
        model[w][s] = pat(w, s);
        tick();
      end
    end
    fill_way_idx = 2'd2; fill_set_idx = 4'd5; fill_data = pat(0, 0);
    model[2][5] = pat(0, 0);
    tick();
    idle();

    vecs[0] = '{0, 0, 0, 32'h03020100};
    vecs[1] = '{3, 1, 2, 32'h57565554};
    vecs[2] = '{15, 3, 15, 32'h3B3A3938};
    vecs[3] = '{9, 2, 7, 32'hC3C2C1C0};
    vecs[4] = '{15, 0, 1, 32'h43424140};
    vecs[5] = '{0, 3, 15, 32'hFFFEFDFC};
    vecs[6] = '{5, 2, 3, 32'h0F0E0D0C};
    vecs[7] = '{5, 2, 15, 32'h3F3E3D3C};
    for (int i = 0; i < 8; i++) begin
      do_read(vecs[i].set, vecs[i].way, vecs[i].word, rv, rl, rw);
      check($sformatf("vec%0d_valid", i), 512'(rv), 512'(1'b1));
      check($sformatf("vec%0d_line", i), rl, model[vecs[i].way][vecs[i].set]);
      check($sformatf("vec%0d_word", i), 512'(rw), 512'(vecs[i].exp_word));
    end

    // Ten back-to-back reads, read r: set r, way r%4, word r.
    for (int c = 0; c < 12; c++) begin
      access_en = (c < 10); access_set_idx = 4'(c);
      hit_en = (c >= 1 && c <= 10); hit_way_idx = 2'((c + 3) % 4); hit_word_idx = 4'(c - 1);
      if (c >= 2) begin
        check($sformatf("b2b%0d_valid", c - 2), 512'(data_valid), 512'(1'b1));
        check($sformatf("b2b%0d_line", c - 2), data_line, model[(c - 2) % 4][c - 2]);
        check($sformatf("b2b%0d_word", c - 2), 512'(data_word),
              512'(model[(c - 2) % 4][c - 2][32*(c - 2) +: 32]));
      end
      tick();
    end
    idle();
    tick();

    // Same-cycle forwarding, plus a fill to another way of the same set.
    access_en = 1'b1; access_set_idx = 4'd5;
    store_en = 1'b1; store_way_idx = 2'd2; store_set_idx = 4'd5;
    store_byte_en = 64'h1; store_data = '0; store_data[7:0] = 8'hAA;
    fill_en = 1'b1; fill_way_idx = 2'd3; fill_set_idx = 4'd5; fill_data = ~pat(0, 0);
    model[2][5] = apply_mask(model[2][5], store_data, store_byte_en);
    model[3][5] = ~pat(0, 0);
    tick();
    idle();
    hit_en = 1'b1; hit_way_idx = 2'd2; hit_word_idx = 4'd0;
    tick();
    idle();
    check("fwdA_valid", 512'(data_valid), 512'(1'b1));
    check("fwdA_word", 512'(data_word), 512'(32'h030201AA));
    check("fwdA_line", data_line, model[2][5]);

    // Stage-2 forwarding; a fill to way 1 in the same cycle must not leak in.
    access_en = 1'b1; access_set_idx = 4'd5;
    tick();
    idle();
    hit_en = 1'b1; hit_way_idx = 2'd2; hit_word_idx = 4'd0;
    store_en = 1'b1; store_way_idx = 2'd2; store_set_idx = 4'd5;
    store_byte_en = 64'h2; store_data = '0; store_data[15:8] = 8'h55;
    fill_en = 1'b1; fill_way_idx = 2'd1; fill_set_idx = 4'd5; fill_data = pat(3, 3);
    model[2][5] = apply_mask(model[2][5], store_data, store_byte_en);
    model[1][5] = pat(3, 3);
    tick();
    idle();
    check("fwdB_word", 512'(data_word), 512'(32'h030255AA));
    check("fwdB_line", data_line, model[2][5]);

    // Window A fill overlaid by a window B store: B has priority.
    for (int i = 0; i < 64; i++) y_line[8*i +: 8] = 8'(255 - i);
    access_en = 1'b1; access_set_idx = 4'd5;
    fill_en = 1'b1; fill_way_idx = 2'd2; fill_set_idx = 4'd5; fill_data = y_line;
    model[2][5] = y_line;
    tick();
    idle();
    hit_en = 1'b1; hit_way_idx = 2'd2; hit_word_idx = 4'd1;
    store_en = 1'b1; store_way_idx = 2'd2; store_set_idx = 4'd5;
    store_byte_en = 64'h10; store_data = '0; store_data[39:32] = 8'h11;
    model[2][5] = apply_mask(model[2][5], store_data, store_byte_en);
    tick();
    idle();
    check("fwdAB_word", 512'(data_word), 512'(32'hF8F9FA11));
    check("fwdAB_line", data_line, model[2][5]);

    // Fill/store conflict on way 3: store stalls two cycles, then commits.
    fill_en = 1'b1; fill_way_idx = 2'd3; fill_set_idx = 4'd1; fill_data = pat(0, 9);
    store_en = 1'b1; store_way_idx = 2'd3; store_set_idx = 4'd2;
    store_byte_en = 64'h1; store_data = '0; store_data[7:0] = 8'h77;
    access_en = 1'b1; access_set_idx = 4'd2;
    #1;
    check("conflict_ready_c1", 512'(store_ready), 512'(1'b0));
    model[3][1] = pat(0, 9);
    tick();
    access_en = 1'b0; hit_en = 1'b1; hit_way_idx = 2'd3; hit_word_idx = 4'd0;
    #1;
    check("conflict_ready_c2", 512'(store_ready), 512'(1'b0));
    tick();
    fill_en = 1'b0; hit_en = 1'b0;
    #1;
    check("retry_ready", 512'(store_ready), 512'(1'b1));
    check("conflict_nowrite_word", 512'(data_word), 512'(32'hCBCAC9C8));
    check("conflict_nowrite_line", data_line, model[3][2]);
    model[3][2] = apply_mask(model[3][2], store_data, store_byte_en);
    tick();
    idle();
    do_read(2, 3, 0, rv, rl, rw);
    check("retry_readback_word", 512'(rw), 512'(32'hCBCAC977));
    check("retry_readback_line", rl, model[3][2]);
    do_read(1, 3, 0, rv, rl, rw);
    check("conflict_fill_word", 512'(rw), 512'(32'h27262524));
    check("conflict_fill_line", rl, pat(0, 9));

    // hit_en=0: no valid, outputs hold the previous result (set 1 way 3).
    access_en = 1'b1; access_set_idx = 4'd4;
    tick();
    access_en = 1'b0; hit_en = 1'b0; hit_way_idx = 2'd1; hit_word_idx = 4'd2;
    tick();
    check("nohit_valid", 512'(data_valid), 512'(1'b0));
    check("nohit_line_hold", data_line, pat(0, 9));
    check("nohit_word_hold", 512'(data_word), 512'(32'h27262524));

    // Reset with a read in flight; writes during reset are ignored.
    access_en = 1'b1; access_set_idx = 4'd7;
    tick();
    access_en = 1'b0; rst = 1'b1; hit_en = 1'b1; hit_way_idx = 2'd0; hit_word_idx = 4'd0;
    fill_en = 1'b1; fill_way_idx = 2'd0; fill_set_idx = 4'd7; fill_data = '1;
    store_en = 1'b1; store_way_idx = 2'd0; store_set_idx = 4'd7;
    store_byte_en = '1; store_data = '0;
    #1;
    check("rst_inflight_ready", 512'(store_ready), 512'(1'b1));
    tick();
    rst = 1'b0;
    idle();
    check("rst_inflight_valid", 512'(data_valid), 512'(1'b0));
    check("rst_inflight_line", data_line, '0);
    check("rst_inflight_word", 512'(data_word), '0);
    tick();
    check("rst_after_valid", 512'(data_valid), 512'(1'b0));
    do_read(7, 0, 0, rv, rl, rw);
    check("post_rst_valid", 512'(rv), 512'(1'b1));
    check("post_rst_word", 512'(rw), 512'(32'h1F1E1D1C));
    check("post_rst_line", rl, model[0][7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_data_array.md
# cache_data_array

Parametrised set-associative cache data array for the L1 caches: one SRAM bank per way, a two-stage read pipeline, a full-line fill port and a byte-masked store port. Stage 1 reads all ways at a set index. Stage 2 takes the hit way from the tag stage and registers the selected line and word. Writes landing while a read is in flight are forwarded, so the output always reflects the latest committed data. It sits between the tag stage and the writeback/load-align logic of the L1 pipeline.

## Interface
- NUM_WAYS, 4, associativity (power of 2, ≥2)
- NUM_SETS, 16, sets per way (power of 2)
- CACHE_LINE_BYTES, 64, line size in bytes
- WORD_BYTES, 4, width of the word-extract output in bytes
- Derived: WAY_W = log2(NUM_WAYS), SET_W = log2(NUM_SETS), LINE_W = 8·CACHE_LINE_BYTES, WORD_W = 8·WORD_BYTES, WIDX_W = log2(CACHE_LINE_BYTES/WORD_BYTES)

Clocking and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- access_en  in  1  stage-1 read request
- access_set_idx  in  SET_W  stage-1 set
- hit_en  in  1  stage-2: the access hit (sampled the cycle after access_en)
- hit_way_idx  in  WAY_W  stage-2 hit way
- hit_word_idx  in  WIDX_W  stage-2 word within line
- data_valid  out  1  stage-2 result valid
- data_line  out  LINE_W  selected line
- data_word  out  WORD_W  word hit_word_idx of data_line (word 0 = bits [WORD_W-1:0])
- fill_en  in  1  full-line write
- fill_way_idx / fill_set_idx  in  WAY_W / SET_W  fill target
- fill_data  in  LINE_W  fill line
- store_en  in  1  store request
- store_ready  out  1  store accepted this cycle (combinational)
- store_way_idx / store_set_idx  in  WAY_W / SET_W  store target
- store_byte_en  in  CACHE_LINE_BYTES  per-byte write mask (bit b covers bits [8b+7:8b])
- store_data  in  LINE_W  store data, line-aligned

## Operation
- Storage: NUM_WAYS single-read, single-write SRAMs, each NUM_SETS × LINE_W with byte write enables.
  - Read in cycle T returns the pre-write contents if the same address is written in T.
  - Contents are not reset.
- Stage 1 (cycle T), access_en=1: read all ways at access_set_idx. Register the set and a valid bit s1_valid.
- Stage 2 (cycle T+1):
  - Select the way at hit_way_idx. Apply forwarding (below).
  - Register data_line and data_word.
  - data_valid ← s1_valid & hit_en.
  - If hit_en=0, data_valid goes 0 and data_line/data_word hold their previous values.
- Write arbitration per cycle:
  - fill always wins.
  - store_ready = !(fill_en && fill_way_idx == store_way_idx).
  - A store is committed only when store_en && store_ready. An unaccepted store must be held by the requester.
  - Fill and store to different ways commit in the same cycle.
- Fill commit: writes all bytes of fill_way_idx[fill_set_idx].
- Store commit: writes only the bytes with store_byte_en=1. store_byte_en=0 with store_en=1 is accepted and is a no-op.
- Forwarding: compare each committed write against the in-flight read's (set, way).
  - Window A: write committed in cycle T with the same set as the stage-1 read.
    - The way must equal the stage-2 hit_way_idx. Hold the write in a one-entry per-way bypass register: data plus byte mask, with a fill = all-ones mask.
  - Window B: write committed in cycle T+1 with the same set as s1 and the same way as hit_way_idx.
  - Merge byte by byte: SRAM data, then window A, then window B (B has highest priority).
  - Fill and store to different ways in the same cycle each forward independently.
- No forwarding for writes committed before T; the SRAM already holds them.

## Timing
- Read latency: access_en at T → data_valid/data_line/data_word at T+2. hit_* are sampled at T+1.
- Throughput: one access per cycle, fully pipelined, no stalls on the read path.
- Write latency: committed at the rising edge ending cycle T. A read issued at T+1 sees it from the SRAM. A read issued at T or T−1 sees it via forwarding.
- Reset (rst=1 on a rising edge): s1_valid=0, data_valid=0, data_line=0, data_word=0 and the bypass registers are cleared on the next edge.
  - A read in flight during reset is dropped; no data_valid for it.
  - Writes presented during reset are ignored; store_ready=1 while rst=1.
- Back-to-back accesses to the same set: each one forwards independently.
- Set index wrap: set NUM_SETS−1 and set 0 are distinct; there is no aliasing.

## Test plan
- Fill way 2 set 5 with line L (byte i = i). Read set 5 with hit way 2, word 3 → at T+2 data_valid=1, data_line=L, data_word=0x0F0E0D0C.
- Same-cycle forwarding: read set 5 at T while storing byte_en=0x1 with byte 0 = 0xAA to way 2 set 5 → data_line byte 0 = 0xAA, the other bytes from L.
- Stage-2 forwarding: store byte 1 = 0x55 at T+1 to way 2 set 5 and fill way 1 set 5 at T+1; hit way 2 → byte 1 = 0x55; the fill does not affect the output.
- Conflict: fill and store both to way 3 (any sets) in one cycle → store_ready=0, the store is not written. Next cycle the store is retried → store_ready=1 and it commits; a readback confirms.
- hit_en=0 at T+1 → data_valid=0 at T+2 and data_line unchanged. Ten back-to-back reads over sets 0..9 → ten consecutive valid outputs in order.
- Assert rst during an in-flight read → data_valid=0 and all outputs 0. A read issued after reset of previously filled data returns correct data (SRAM retained).
